// File: rtl/legv8_pkg.sv
// Shared LEGv8 encoding constants for the IF/ID pipeline stage and its hazard logic.
package legv8_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [4:0]  XZR_IDX   = 5'd31;
  localparam logic [10:0] OPC_STUR  = 11'h7C0;
  localparam logic [7:0]  OPC_CBZ   = 8'hB4;

  localparam int RT_LSB   = 0;
  localparam int RT_MSB   = 4;
  localparam int RN_LSB   = 5;
  localparam int RN_MSB   = 9;
  localparam int RM_LSB   = 16;
  localparam int RM_MSB   = 20;
  localparam int STUR_LSB = 21;
  localparam int CBZ_LSB  = 24;
  localparam int OPC_MSB  = 31;

endpackage

// File: rtl/if_id_stage_if.sv
// Fetch-to-decode bundle for the IF/ID stage: fetch/ID-EX inputs and ID-side outputs.
interface if_id_stage_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
);
  logic [ADDR_W-1:0]  PCIn;
  logic [INSTR_W-1:0] InstructionIn;
  logic               Flush;
  logic               IDEX_MemRead;
  logic [4:0]         IDEX_Rd;
  logic [ADDR_W-1:0]  PCOut;
  logic [INSTR_W-1:0] InstructionOut;
  logic               ValidOut;
  logic               PCWrite;
  logic               ControlBubble;

  modport master (
    output PCIn, InstructionIn, Flush, IDEX_MemRead, IDEX_Rd,
    input  PCOut, InstructionOut, ValidOut, PCWrite, ControlBubble
  );

  modport slave (
    input  PCIn, InstructionIn, Flush, IDEX_MemRead, IDEX_Rd,
    output PCOut, InstructionOut, ValidOut, PCWrite, ControlBubble
  );
endinterface

// File: rtl/hazard_detection_unit.sv
// Combinational load-use hazard detector for the instruction currently held in ID.
module hazard_detection_unit
  import legv8_pkg::*;
#(
  parameter int INSTR_W = 32
) (
  input  logic               memread_i,
  input  logic [4:0]         rd_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               valid_i,
  output logic               hazard_o
);

  logic [4:0] rn;
  logic [4:0] rm;
  logic [4:0] rt;
  logic       is_stur;
  logic       is_cbz;
  logic       unused_bits;

  assign rn      = instr_i[RN_MSB:RN_LSB];
  assign rm      = instr_i[RM_MSB:RM_LSB];
  assign rt      = instr_i[RT_MSB:RT_LSB];
  assign is_stur = (instr_i[OPC_MSB:STUR_LSB] == OPC_STUR);
  assign is_cbz  = (instr_i[OPC_MSB:CBZ_LSB] == OPC_CBZ);

  // Bits 15:10 carry shamt/offset fields that never name a register.
  assign unused_bits = ^instr_i[15:10];

  // Rt is only a source for stores and compare-and-branch; elsewhere it is a destination.
  assign hazard_o = memread_i && (rd_i != XZR_IDX) && valid_i &&
                    ((rd_i == rn) || (rd_i == rm) ||
                     ((is_stur || is_cbz) && (rd_i == rt)));

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with flush/stall priority and load-use hazard detection.
// Optional saturating stall/flush counters are built when IF_ID_PERF_CNT_EN is defined.
module if_id_stage
  import legv8_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  PCIn,
  input  logic [INSTR_W-1:0] InstructionIn,
  input  logic               Flush,
  input  logic               IDEX_MemRead,
  input  logic [4:0]         IDEX_Rd,
  output logic [ADDR_W-1:0]  PCOut,
  output logic [INSTR_W-1:0] InstructionOut,
  output logic               ValidOut,
  output logic               PCWrite,
  output logic               ControlBubble,
  output logic [CNT_W-1:0]   StallCount,
  output logic [CNT_W-1:0]   FlushCount
);

  localparam logic [INSTR_W-1:0] NOP_W = INSTR_W'(NOP_INSTR);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               hazard;

  hazard_detection_unit #(
    .INSTR_W (INSTR_W)
  ) u_hdu (
    .memread_i (IDEX_MemRead),
    .rd_i      (IDEX_Rd),
    .instr_i   (instr_q),
    .valid_i   (valid_q),
    .hazard_o  (hazard)
  );

  // NOTE: every always_comb output is defaulted first so no path leaves it unassigned (no latch).
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (Flush) begin
      pc_d    = PCIn;
      instr_d = NOP_W;
      valid_d = 1'b0;
    end else if (!hazard) begin
      pc_d    = PCIn;
      instr_d = InstructionIn;
      valid_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample the same edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      instr_q <= NOP_W;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign PCOut          = pc_q;
  assign InstructionOut = instr_q;
  assign ValidOut       = valid_q;
  assign PCWrite        = ~hazard;
  assign ControlBubble  = hazard | ~valid_q;

`ifdef IF_ID_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // A flush squashes the stalled slot, so it is counted as a flush rather than a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hazard && !Flush && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (Flush && (flush_cnt_q != '1))            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`else
  assign StallCount = '0;
  assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage: reset, flow, load-use stalls, flush, async reset.
module tb_if_id_stage;
  import legv8_pkg::*;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 32;

`ifdef IF_ID_PERF_CNT_EN
  localparam logic [63:0] PERF = 64'd1;
`else
  localparam logic [63:0] PERF = 64'd0;
`endif

  logic clk;
  logic rst_n;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  int n_checks = 0;
  int n_errors = 0;

  if_id_stage_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  if_id_stage #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .PCIn           (bus.PCIn),
    .InstructionIn  (bus.InstructionIn),
    .Flush          (bus.Flush),
    .IDEX_MemRead   (bus.IDEX_MemRead),
    .IDEX_Rd        (bus.IDEX_Rd),
    .PCOut          (bus.PCOut),
    .InstructionOut (bus.InstructionOut),
    .ValidOut       (bus.ValidOut),
    .PCWrite        (bus.PCWrite),
    .ControlBubble  (bus.ControlBubble),
    .StallCount     (stall_count),
    .FlushCount     (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic [63:0] pc,
                            input logic [31:0] instr, input logic valid);
    check({tag, ".pc"},    64'(bus.PCOut),          pc);
    check({tag, ".instr"}, 64'(bus.InstructionOut), 64'(instr));
    check({tag, ".valid"}, 64'(bus.ValidOut),       64'(valid));
  endtask

  task automatic check_ctl(input string tag, input logic pcw, input logic bub);
    check({tag, ".pcwrite"}, 64'(bus.PCWrite),       64'(pcw));
    check({tag, ".bubble"},  64'(bus.ControlBubble), 64'(bub));
  endtask

  task automatic check_cnt(input string tag, input logic [63:0] stalls, input logic [63:0] flushes);
    check({tag, ".stallcnt"}, 64'(stall_count), PERF * stalls);
    check({tag, ".flushcnt"}, 64'(flush_count), PERF * flushes);
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.PCIn           = '0;
    bus.InstructionIn  = '0;
    bus.Flush          = 1'b0;
    bus.IDEX_MemRead   = 1'b0;
    bus.IDEX_Rd        = 5'd0;

    repeat (2) @(negedge clk);
    check_regs("reset", 64'h0, 32'h0, 1'b0);
    check_ctl("reset", 1'b1, 1'b1);
    check_cnt("reset", 0, 0);

    // Reset release, then normal flow
    rst_n             = 1'b1;
    bus.PCIn          = 64'h0;
    bus.InstructionIn = 32'h8B02_0020;
    @(negedge clk);
    check_regs("flow0", 64'h0, 32'h8B02_0020, 1'b1);
    check_ctl("flow0", 1'b1, 1'b0);
    bus.PCIn = 64'h4;
    @(negedge clk);
    check_regs("flow4", 64'h4, 32'h8B02_0020, 1'b1);

    // Load-use on Rn=1
    bus.IDEX_MemRead  = 1'b1;
    bus.IDEX_Rd       = 5'd1;
    bus.PCIn          = 64'h8;
    bus.InstructionIn = 32'h8B03_0041;
    #1;
    check_ctl("rn_haz", 1'b0, 1'b1);
    @(negedge clk);
    check_regs("rn_hold", 64'h4, 32'h8B02_0020, 1'b1);
    check_cnt("rn_hold", 1, 0);
    bus.IDEX_MemRead = 1'b0;
    #1;
    check_ctl("rn_release", 1'b1, 1'b0);
    @(negedge clk);
    check_regs("rn_adv", 64'h8, 32'h8B03_0041, 1'b1);
    check_cnt("rn_adv", 1, 0);

    // ID holds 0x8B030041: Rn=2, Rm=3, Rt=1 (Rt is a destination for ADD)
    bus.IDEX_MemRead = 1'b1;
    bus.IDEX_Rd      = 5'd3;
    #1 check_ctl("rm_haz", 1'b0, 1'b1);
    bus.IDEX_Rd      = 5'd4;
    #1 check_ctl("rd_nomatch", 1'b1, 1'b0);
    bus.IDEX_Rd      = 5'd1;
    #1 check_ctl("add_rt_nohaz", 1'b1, 1'b0);
    bus.IDEX_MemRead = 1'b0;
    bus.IDEX_Rd      = 5'd3;
    #1 check_ctl("no_memread", 1'b1, 1'b0);

    // XZR exemption: Rn=Rm=31, IDEX_Rd=31
    bus.PCIn          = 64'hC;
    bus.InstructionIn = 32'h8B1F_03E0;
    @(negedge clk);
    check_regs("xzr_load", 64'hC, 32'h8B1F_03E0, 1'b1);
    bus.IDEX_MemRead = 1'b1;
    bus.IDEX_Rd      = 5'd31;
    #1 check_ctl("xzr", 1'b1, 1'b0);
    bus.PCIn          = 64'h10;
    bus.InstructionIn = 32'hF800_0001;
    @(negedge clk);
    check_regs("xzr_adv", 64'h10, 32'hF800_0001, 1'b1);

    // STUR source hazard on Rt=1
    bus.IDEX_Rd = 5'd1;
    #1 check_ctl("stur_rt", 1'b0, 1'b1);

    // Flush wins over hazard; PCWrite still reflects the hazard this cycle
    bus.Flush = 1'b1;
    bus.PCIn  = 64'h40;
    #1 check_ctl("flush_haz", 1'b0, 1'b1);
    @(negedge clk);
    check_regs("flushed", 64'h40, 32'h0, 1'b0);
    check_ctl("flushed", 1'b1, 1'b1);
    check_cnt("flushed", 1, 1);
    bus.Flush = 1'b0;

    // CBZ source hazard on Rt=1
    bus.IDEX_MemRead  = 1'b0;
    bus.PCIn          = 64'h44;
    bus.InstructionIn = 32'hB400_0041;
    @(negedge clk);
    check_regs("cbz_load", 64'h44, 32'hB400_0041, 1'b1);
    bus.IDEX_MemRead = 1'b1;
    bus.IDEX_Rd      = 5'd5;
    #1 check_ctl("cbz_nomatch", 1'b1, 1'b0);
    bus.IDEX_Rd      = 5'd1;
    #1 check_ctl("cbz_rt", 1'b0, 1'b1);

    // Async reset mid-stall discards the held instruction
    bus.PCIn = 64'h48;
    @(negedge clk);
    check_regs("cbz_hold", 64'h44, 32'hB400_0041, 1'b1);
    check_cnt("cbz_hold", 2, 1);
    #2 rst_n = 1'b0;
    #1;
    check_regs("async_rst", 64'h0, 32'h0, 1'b0);
    check_ctl("async_rst", 1'b1, 1'b1);
    check_cnt("async_rst", 0, 0);
    @(negedge clk);
    check_regs("rst_held", 64'h0, 32'h0, 1'b0);
    rst_n             = 1'b1;
    bus.IDEX_MemRead  = 1'b0;
    bus.PCIn          = 64'h100;
    bus.InstructionIn = 32'h8B02_0020;
    @(negedge clk);
    check_regs("post_rst", 64'h100, 32'h8B02_0020, 1'b1);
    check_cnt("post_rst", 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- ADDR_W, 64, PC width.
- INSTR_W, 32, instruction width.
- CNT_W, 32, perf counter width.
REQ-002 SHALL have ports (name, direction, width, meaning), one per line; there is one clock, and reset is asynchronous and active-low:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- PCIn, in, ADDR_W, fetched PC from fetch stage.
- InstructionIn, in, INSTR_W, fetched instruction.
- Flush, in, 1, taken branch (PCSrc) squashes the fetched instruction.
- IDEX_MemRead, in, 1, instruction in ID/EX is a load.
- IDEX_Rd, in, 5, destination register of the ID/EX instruction.
- PCOut, out, ADDR_W, registered PC to ID.
- InstructionOut, out, INSTR_W, registered instruction to ID.
- ValidOut, out, 1, ID holds a real instruction.
- PCWrite, out, 1, fetch PC update enable.
- ControlBubble, out, 1, ID forces all control signals to zero.
- StallCount, out, CNT_W, load-use stall cycles (REQ-017).
- FlushCount, out, CNT_W, flushed cycles (REQ-017).

Function
REQ-003 SHALL decode fields from InstructionOut: Rn=[9:5], Rm=[20:16], Rt=[4:0].
REQ-004 SHALL assert hazard when all of these hold: IDEX_MemRead=1, IDEX_Rd!=31, ValidOut=1, and IDEX_Rd equals Rn or Rm.
- Hazard SHALL also assert on IDEX_Rd==Rt when opcode is STUR (InstructionOut[31:21]==11'h7C0) or CBZ ([31:24]==8'hB4).
REQ-005 hazard SHALL be combinational from the current register contents, with zero-cycle latency to PCWrite and ControlBubble.
REQ-006 PCWrite SHALL be ~hazard; ControlBubble SHALL be hazard | ~ValidOut.
REQ-007 Register update priority, evaluated per clk edge:
- Flush=1: PCOut<=PCIn, InstructionOut<=NOP (32'h0), ValidOut<=0.
- Otherwise hazard=1: hold all registers.
- Otherwise: PCOut<=PCIn, InstructionOut<=InstructionIn, ValidOut<=1.
REQ-008 Flush and hazard asserted in the same cycle: Flush SHALL win, and PCWrite SHALL still follow REQ-006 for that cycle.
REQ-009 Stall SHALL last exactly as long as hazard is true; a single load produces a one-cycle stall once ID/EX receives the bubble.
REQ-010 Pipeline state machine (implicit in ValidOut and hazard):
- States: EMPTY (ValidOut=0), RUN, STALL.
- EMPTY->RUN on a non-flush edge.
- RUN->STALL when hazard.
- STALL->RUN when hazard drops.
- Any state->EMPTY on Flush.
REQ-011 PC width arithmetic SHALL be pass-through only; no wrap or adder logic in this block.

Reset
REQ-012 rst_n low SHALL asynchronously set PCOut=0, InstructionOut=NOP, ValidOut=0, StallCount=0, FlushCount=0.
REQ-013 During reset, PCWrite=1 and ControlBubble=1.
REQ-014 Reset release SHALL be synchronous to clk; the first rising edge with rst_n high performs a normal REQ-007 update.
REQ-015 Reset asserted mid-stall SHALL discard the held instruction, with no replay.

Configuration
REQ-016 Macro IF_ID_PERF_CNT_EN SHALL gate the performance counters.
REQ-017 With IF_ID_PERF_CNT_EN defined:
- StallCount SHALL increment on each edge where hazard=1 and Flush=0.
- FlushCount SHALL increment on each edge where Flush=1.
- Both counters SHALL saturate at all-ones.
REQ-018 Without IF_ID_PERF_CNT_EN, StallCount and FlushCount SHALL be constant 0 and no counter flops SHALL be inferred.

Structure
REQ-019 Shared package legv8_pkg SHALL hold:
- NOP_INSTR (32'h0).
- XZR_IDX (5'd31).
- OPC_STUR (11'h7C0).
- OPC_CBZ (8'hB4).
- Field bit-position constants.
REQ-020 Hazard logic SHALL be a sub-module hazard_detection_unit.
- Inputs: IDEX_MemRead, IDEX_Rd, instruction, valid.
- Output: hazard.
- Purely combinational.
REQ-021 if_id_stage SHALL contain only the pipeline registers, the priority mux, the optional counters, and the hazard_detection_unit instance.

Verification
REQ-022 Reset then normal flow: after rst_n rises, PCIn=0x0 then 0x4, InstructionIn=0x8B020020 -> one edge later PCOut=0x0 and ValidOut=1; the next edge gives PCOut=0x4.
REQ-023 Load-use on Rn: ID holds 0x8B020020 (Rn=1); IDEX_MemRead=1, IDEX_Rd=1.
- Same cycle: PCWrite=0, ControlBubble=1.
- Next edge: registers unchanged.
- Then IDEX_MemRead=0: the following edge advances.
- StallCount=1 when IF_ID_PERF_CNT_EN is defined.
REQ-024 XZR exemption: IDEX_MemRead=1, IDEX_Rd=31, Rn=31 -> PCWrite=1, no stall.
REQ-025 Flush during stall: hazard=1 and Flush=1 -> next edge InstructionOut=0, ValidOut=0, ControlBubble=1; FlushCount=1.
REQ-026 STUR source hazard: InstructionOut=0xF8000001 (Rt=1), IDEX_MemRead=1, IDEX_Rd=1 -> PCWrite=0.
REQ-027 Async reset mid-stall: rst_n low between edges -> outputs go to REQ-012 values before the next clk edge.
